// File: rtl/ex_div_if.sv
// EX <-> divider request/result bundle for DIV/DIVU.
// DIV_ANNUL_EN adds the annul abort line.
interface ex_div_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
`ifdef DIV_ANNUL_EN
    logic                  annul;
`endif
    logic [2*DATA_W-1:0]   result;
    logic                  ready;

    modport master (
        output start, signed_div, opdata1, opdata2,
`ifdef DIV_ANNUL_EN
        output annul,
`endif
        input  result, ready
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2,
`ifdef DIV_ANNUL_EN
        input  annul,
`endif
        output result, ready
    );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for EX-stage DIV/DIVU; one division in flight.
// Optional abort input enabled by defining DIV_ANNUL_EN.
module ex_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   div
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  sdiv_q, sdiv_d;
    logic                  ndvd_q, ndvd_d;
    logic                  ndvs_q, ndvs_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  annul_c;
    logic [DATA_W-1:0]     mag1_c, mag2_c;
    logic [DATA_W:0]       shifted_c;
    logic                  no_borrow_c;
    logic [DATA_W-1:0]     rem_step_c, quo_step_c;
    logic [DATA_W-1:0]     rem_fix_c, quo_fix_c;

`ifdef DIV_ANNUL_EN
    assign annul_c = div.annul;
`else
    assign annul_c = 1'b0;
`endif

    // Operand magnitudes; the most negative value maps onto itself (mod 2^DATA_W).
    assign mag1_c = (div.signed_div && div.opdata1[DATA_W-1]) ? (~div.opdata1 + DATA_W'(1)) : div.opdata1;
    assign mag2_c = (div.signed_div && div.opdata2[DATA_W-1]) ? (~div.opdata2 + DATA_W'(1)) : div.opdata2;

    // One restoring step; the shifted partial remainder needs an extra bit before the trial subtract.
    assign shifted_c   = {rem_q, quo_q[DATA_W-1]};
    assign no_borrow_c = (shifted_c >= {1'b0, dvs_q});
    assign rem_step_c  = no_borrow_c ? DATA_W'(shifted_c - {1'b0, dvs_q}) : shifted_c[DATA_W-1:0];
    assign quo_step_c  = {quo_q[DATA_W-2:0], no_borrow_c};

    assign quo_fix_c = (sdiv_q && (ndvd_q ^ ndvs_q)) ? (~quo_step_c + DATA_W'(1)) : quo_step_c;
    assign rem_fix_c = (sdiv_q && ndvd_q) ? (~rem_step_c + DATA_W'(1)) : rem_step_c;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sdiv_q   <= 1'b0;
            ndvd_q   <= 1'b0;
            ndvs_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sdiv_q   <= sdiv_d;
            ndvd_q   <= ndvd_d;
            ndvs_q   <= ndvs_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Next state; ready/result are driven only while in END and cleared on every other path.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sdiv_d   = sdiv_q;
        ndvd_d   = ndvd_q;
        ndvs_d   = ndvs_q;
        ready_d  = 1'b0;
        result_d = '0;

        case (state_q)
            S_IDLE: begin
                if (div.start && !annul_c) begin
                    if (div.opdata2 == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_ON;
                        rem_d   = '0;
                        quo_d   = mag1_c;
                        dvs_d   = mag2_c;
                        sdiv_d  = div.signed_div;
                        ndvd_d  = div.opdata1[DATA_W-1];
                        ndvs_d  = div.opdata2[DATA_W-1];
                        cnt_d   = '0;
                    end
                end
            end
            S_ZERO: begin
                if (annul_c) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                    rem_d   = '0;
                    quo_d   = '0;
                end
            end
            S_ON: begin
                if (annul_c) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step_c;
                    quo_d = quo_step_c;
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_END;
                        rem_d   = rem_fix_c;
                        quo_d   = quo_fix_c;
                    end
                end
            end
            S_END: begin
                // First END cycle always presents the result so a dropped start still sees one ready pulse.
                if (annul_c || (ready_q && !div.start)) begin
                    state_d = S_IDLE;
                end else begin
                    ready_d  = 1'b1;
                    result_d = {rem_q, quo_q};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign div.result = result_q;
    assign div.ready  = ready_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized self-checking bench for ex_div_unit against a plain-arithmetic division model.
// Define DIV_ANNUL_EN to also exercise the abort input.
module tb_ex_div_unit;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ex_div_if #(.DATA_W(DATA_W)) div_if ();

    ex_div_unit #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .div (div_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on wide signed integers, then reduced mod 2^32.
    function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
        end else begin
            sa = $signed({32'd0, a});
            sb = $signed({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, count latency, compare result, then release and confirm return to idle.
    task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input int extra, input string tag);
        int          cyc;
        bit          early;
        logic [63:0] exp;
        int          exp_lat;
        exp     = ref_div(sd, a, b);
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        div_if.start      = 1'b1;
        div_if.signed_div = sd;
        div_if.opdata1    = a;
        div_if.opdata2    = b;
        tick();
        cyc   = 0;
        early = 1'b0;
        while (cyc < 100) begin
            div_if.opdata1    = $urandom;
            div_if.opdata2    = $urandom;
            div_if.signed_div = 1'($urandom);
            if (!hold && cyc == 3) div_if.start = 1'b0;
            tick();
            cyc++;
            if (div_if.ready) break;
            if (div_if.result != '0) early = 1'b1;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " result"}, div_if.result, exp);
        chk({tag, " result zero before ready"}, 64'(early), 64'd0);
        for (int i = 0; i < extra; i++) begin
            tick();
            chk({tag, " held ready"}, 64'(div_if.ready), 64'd1);
            chk({tag, " held result"}, div_if.result, exp);
        end
        div_if.start = 1'b0;
        tick();
        chk({tag, " ready after release"}, 64'(div_if.ready), 64'd0);
        chk({tag, " result after release"}, div_if.result, 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        bit          never;
        rst               = 1'b1;
        div_if.start      = 1'b0;
        div_if.signed_div = 1'b0;
        div_if.opdata1    = '0;
        div_if.opdata2    = '0;
`ifdef DIV_ANNUL_EN
        div_if.annul      = 1'b0;
`endif
        repeat (3) tick();
        chk("reset ready", 64'(div_if.ready), 64'd0);
        chk("reset result", div_if.result, 64'd0);
        rst = 1'b0;
        tick();

        run_div(1'b0, 32'd100, 32'd7, 1'b1, 2, "divu 100/7");
        chk("divu 100/7 constant", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div -7/2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div 7/-2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div min/-1");
        run_div(1'b0, 32'd5, 32'd0, 1'b1, 1, "divu by zero");
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b1, 0, "div by zero");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, "divu max/1");
        run_div(1'b0, 32'd3, 32'hFFFF_FFFF, 1'b0, 0, "divu small/max dropped start");
        run_div(1'b1, 32'h8000_0000, 32'd3, 1'b0, 0, "div min/3 dropped start");

        // Reset mid-division at iteration 15, then a fresh division must take the full latency.
        @(negedge clk);
        div_if.start = 1'b1; div_if.signed_div = 1'b0;
        div_if.opdata1 = 32'd1000; div_if.opdata2 = 32'd3;
        tick();
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        div_if.start = 1'b0;
        chk("reset mid-op ready", 64'(div_if.ready), 64'd0);
        chk("reset mid-op result", div_if.result, 64'd0);
        run_div(1'b0, 32'd1000, 32'd3, 1'b1, 0, "after reset");

        // Reset while the result is being presented.
        @(negedge clk);
        div_if.start = 1'b1; div_if.signed_div = 1'b0;
        div_if.opdata1 = 32'd50; div_if.opdata2 = 32'd0;
        repeat (4) tick();
        chk("ready before end reset", 64'(div_if.ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        div_if.start = 1'b0;
        chk("reset in end ready", 64'(div_if.ready), 64'd0);
        chk("reset in end result", div_if.result, 64'd0);
        tick();

`ifdef DIV_ANNUL_EN
        // Abort at iteration 10: no result may ever appear.
        @(negedge clk);
        div_if.start = 1'b1; div_if.signed_div = 1'b0;
        div_if.opdata1 = 32'd1000; div_if.opdata2 = 32'd7;
        tick();
        repeat (10) tick();
        div_if.annul = 1'b1;
        div_if.start = 1'b0;
        tick();
        div_if.annul = 1'b0;
        never = 1'b1;
        repeat (40) begin
            tick();
            if (div_if.ready || div_if.result != '0) never = 1'b0;
        end
        chk("annul in on silent", 64'(never), 64'd1);
        run_div(1'b0, 32'd9, 32'd3, 1'b1, 0, "after annul 9/3");

        // Abort in IDLE blocks acceptance of a simultaneous start.
        @(negedge clk);
        div_if.start = 1'b1; div_if.annul = 1'b1;
        div_if.opdata1 = 32'd8; div_if.opdata2 = 32'd2;
        tick();
        div_if.start = 1'b0; div_if.annul = 1'b0;
        never = 1'b1;
        repeat (40) begin
            tick();
            if (div_if.ready) never = 1'b0;
        end
        chk("annul in idle blocks start", 64'(never), 64'd1);

        // Abort while presenting the result.
        @(negedge clk);
        div_if.start = 1'b1; div_if.signed_div = 1'b0;
        div_if.opdata1 = 32'd8; div_if.opdata2 = 32'd0;
        repeat (4) tick();
        div_if.annul = 1'b1;
        tick();
        chk("annul in end ready", 64'(div_if.ready), 64'd0);
        chk("annul in end result", div_if.result, 64'd0);
        div_if.annul = 1'b0;
        div_if.start = 1'b0;
        tick();
`endif

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_div(1'($urandom), a, b, 1'($urandom), 0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
